// File: rtl/irq_pending.sv
// Interrupt pending/arbitration stage: sticky edge-detected pending bits, a software mask,
// and a REQ/ACK/EOI handshake driven by an external priority encoder result.
module irq_pending #(
    parameter int unsigned N_IRQ     = 4,
    parameter int unsigned IDX_WIDTH = $clog2(N_IRQ)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_IRQ-1:0]     IRQ_IN,
    input  logic                 MASK_WE,
    input  logic [N_IRQ-1:0]     MASK_DATA,
    output logic [N_IRQ-1:0]     MASK,
    output logic [N_IRQ-1:0]     PENDING,
    output logic [N_IRQ-1:0]     ACTIVE,
    input  logic [IDX_WIDTH-1:0] ENC_IDX,
    output logic                 IRQ_REQ,
    output logic [IDX_WIDTH-1:0] IRQ_ID,
    input  logic                 IRQ_ACK,
    input  logic                 IRQ_EOI,
    output logic                 IN_SERVICE
);

    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [N_IRQ-1:0]       r_prev;
    logic [N_IRQ-1:0]       r_pending;
    logic [N_IRQ-1:0]       r_mask;
    logic [IDX_WIDTH-1:0]   r_irq_id;

    logic [N_IRQ-1:0]       w_edge;
    logic [N_IRQ-1:0]       w_clr;
    logic [N_IRQ-1:0]       w_active;
    logic                   w_ack_taken;
    logic                   w_capture;

    assign w_edge      = IRQ_IN & ~r_prev;
    assign w_active    = r_pending & r_mask;
    assign w_ack_taken = (r_state == StReq) && IRQ_ACK;
    assign w_capture   = (r_state == StIdle) && (w_active != '0);

    always_comb begin
        w_clr = '0;
        if (w_ack_taken) begin
            w_clr[r_irq_id] = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:    if (w_active != '0) w_state_next = StReq;
            StReq:     if (IRQ_ACK)        w_state_next = StService;
            StService: if (IRQ_EOI)        w_state_next = StIdle;
            default:                       w_state_next = StIdle;
        endcase
    end

    // prev resets to all-ones so lines already high at reset release raise no edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= StIdle;
            r_prev    <= '1;
            r_pending <= '0;
            r_mask    <= '0;
            r_irq_id  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_prev    <= IRQ_IN;
            // a new edge on the bit being acknowledged survives the clear
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (MASK_WE) begin
                r_mask <= MASK_DATA;
            end
            if (w_capture) begin
                r_irq_id <= ENC_IDX;
            end
        end
    end

    assign MASK       = r_mask;
    assign PENDING    = r_pending;
    assign ACTIVE     = w_active;
    assign IRQ_ID     = r_irq_id;
    assign IRQ_REQ    = (r_state == StReq);
    assign IN_SERVICE = (r_state == StService);

endmodule

// File: tb/tb_irq_pending.sv
// Directed bench for irq_pending: expected request IDs go into a scoreboard queue that a
// monitor drains on each IRQ_REQ rise; register/state values are checked inline.
module tb_irq_pending;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq_in;
    logic          mask_we;
    logic [N-1:0]  mask_data;
    logic [N-1:0]  mask;
    logic [N-1:0]  pending;
    logic [N-1:0]  active;
    logic [IW-1:0] enc_idx;
    logic          irq_req;
    logic [IW-1:0] irq_id;
    logic          irq_ack;
    logic          irq_eoi;
    logic          in_service;

    int checks = 0;
    int errors = 0;
    logic [IW-1:0] sb_q[$];

    always #5 clk = ~clk;

    irq_pending #(.N_IRQ(N), .IDX_WIDTH(IW)) dut (
        .CLK(clk), .RST(rst), .IRQ_IN(irq_in), .MASK_WE(mask_we), .MASK_DATA(mask_data),
        .MASK(mask), .PENDING(pending), .ACTIVE(active), .ENC_IDX(enc_idx),
        .IRQ_REQ(irq_req), .IRQ_ID(irq_id), .IRQ_ACK(irq_ack), .IRQ_EOI(irq_eoi),
        .IN_SERVICE(in_service)
    );

    // Priority encoder model: lowest set bit wins, all-ones when empty
    always_comb begin
        enc_idx = '1;
        for (int i = N - 1; i >= 0; i--) begin
            if (active[i]) enc_idx = IW'(i);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mask_write(input logic [N-1:0] val);
        mask_we = 1'b1; mask_data = val;
        step();
        mask_we = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] val);
        irq_in = val;
        step();
        irq_in = '0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    task automatic eoi();
        irq_eoi = 1'b1;
        step();
        irq_eoi = 1'b0;
    endtask

    // Monitor: every rising IRQ_REQ must match the next queued ID
    initial begin
        logic          req_prev;
        logic [IW-1:0] exp_id;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (irq_req === 1'b1 && req_prev !== 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL req_unexpected: got id %0d expected no request at %0t",
                             irq_id, $time);
                end else begin
                    exp_id = sb_q.pop_front();
                    if (irq_id !== exp_id) begin
                        errors++;
                        $display("FAIL req_id: got %0d expected %0d at %0t",
                                 irq_id, exp_id, $time);
                    end
                end
            end
            req_prev = irq_req;
        end
    end

    initial begin
        rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_data = '0;
        irq_ack = 1'b0; irq_eoi = 1'b0;
        step(); step();
        chk("rst_mask", 32'(mask), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_req", 32'(irq_req), 0);
        chk("rst_insvc", 32'(in_service), 0);
        chk("rst_id", 32'(irq_id), 0);
        rst = 1'b0;
        step();

        // Single edge on line 2
        mask_write(4'b1111);
        chk("mask_wr", 32'(mask), 32'hf);
        pulse(4'b0100);
        chk("p2_pending_t1", 32'(pending), 32'h4);
        chk("p2_req_t1", 32'(irq_req), 0);
        sb_q.push_back(2'd2);
        step();
        chk("p2_req_t2", 32'(irq_req), 1);
        chk("p2_id_t2", 32'(irq_id), 2);
        ack();
        chk("p2_ack_req", 32'(irq_req), 0);
        chk("p2_ack_insvc", 32'(in_service), 1);
        chk("p2_ack_pending", 32'(pending), 0);
        eoi();
        chk("p2_eoi_insvc", 32'(in_service), 0);
        chk("p2_eoi_req", 32'(irq_req), 0);

        // Simultaneous edges on lines 3 and 1
        pulse(4'b1010);
        chk("p31_pending", 32'(pending), 32'ha);
        sb_q.push_back(2'd1);
        sb_q.push_back(2'd3);
        step();
        chk("p31_id1", 32'(irq_id), 1);
        ack();
        chk("p31_pending_ack", 32'(pending), 32'h8);
        eoi();
        chk("p31_idle_req", 32'(irq_req), 0);
        chk("p31_idle_insvc", 32'(in_service), 0);
        step();
        chk("p31_req2", 32'(irq_req), 1);
        chk("p31_id3", 32'(irq_id), 3);
        ack();
        eoi();
        chk("p31_done_pending", 32'(pending), 0);

        // Masked line 0 waits for mask write
        mask_write(4'b1110);
        pulse(4'b0001);
        chk("m0_pending", 32'(pending), 32'h1);
        step(); step();
        chk("m0_req_masked", 32'(irq_req), 0);
        chk("m0_active", 32'(active), 0);
        mask_write(4'b1111);
        chk("m0_active_after", 32'(active), 32'h1);
        chk("m0_req_m1", 32'(irq_req), 0);
        sb_q.push_back(2'd0);
        step();
        chk("m0_req_m2", 32'(irq_req), 1);
        chk("m0_id", 32'(irq_id), 0);
        ack();
        eoi();

        // Set wins over clear; masking in REQ keeps the request
        pulse(4'b0100);
        sb_q.push_back(2'd2);
        step();
        chk("sw_id", 32'(irq_id), 2);
        irq_in = 4'b0100; irq_ack = 1'b1;
        step();
        irq_in = '0; irq_ack = 1'b0;
        chk("sw_insvc", 32'(in_service), 1);
        chk("sw_pending", 32'(pending), 32'h4);
        eoi();
        sb_q.push_back(2'd2);
        step();
        chk("sw_rereq", 32'(irq_req), 1);
        mask_write(4'b0000);
        chk("hold_req", 32'(irq_req), 1);
        chk("hold_id", 32'(irq_id), 2);
        ack();
        chk("hold_insvc", 32'(in_service), 1);
        chk("hold_pending", 32'(pending), 0);
        mask_write(4'b1111);
        eoi();

        // Line high through reset release, then level held high
        irq_in = 4'b0001; rst = 1'b1;
        step();
        rst = 1'b0;
        step(); step();
        chk("hi_rst_pending", 32'(pending), 0);
        irq_in = '0;
        step();
        irq_in = 4'b0001;
        step(); step(); step();
        chk("hi_one_set", 32'(pending), 32'h1);
        chk("hi_no_req", 32'(irq_req), 0);
        mask_write(4'b1111);
        sb_q.push_back(2'd0);
        step();
        ack();
        eoi();
        step();
        chk("hi_no_reset", 32'(pending), 0);
        irq_in = '0;
        step();

        // Reset in SERVICE with pending 1010
        pulse(4'b1010);
        sb_q.push_back(2'd1);
        step();
        ack();
        pulse(4'b0010);
        chk("rs_pending", 32'(pending), 32'ha);
        chk("rs_insvc", 32'(in_service), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_req", 32'(irq_req), 0);
        chk("rs_insvc_after", 32'(in_service), 0);
        chk("rs_pending_after", 32'(pending), 0);
        chk("rs_mask_after", 32'(mask), 0);
        step();
        ack();
        eoi();
        chk("sp_req", 32'(irq_req), 0);
        chk("sp_insvc", 32'(in_service), 0);
        chk("sp_pending", 32'(pending), 0);
        step(); step();
        chk("sb_drained", 32'(sb_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
